thresh_search: RTL and testbench
================================

// Module: thresh_search
// PURPOSE
//  Successive-approximation controller: drives a probe value x_out into an external
//  constant-threshold comparator (eq = x==T, grt = x>T) and binary-searches for T.
//  Consumes the comparator's eq/grt flags; produces the discovered threshold.
//  Sits beside the comparator for self-test/calibration of its hard-wired threshold.
// PARAMETERS
//  WIDTH  8  probe/result width; search space 0 .. 2**WIDTH-1
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          asynchronous, active-high reset
//  start     in   1          request a search; sampled only in IDLE
//  eq_in     in   1          comparator equal flag for current x_out
//  grt_in    in   1          comparator greater flag for current x_out
//  x_out     out  WIDTH      registered probe value to comparator
//  busy      out  1          high in PROBE/SETTLE
//  done      out  1          one-cycle pulse when search ends
//  found     out  1          held: last search hit eq
//  result    out  WIDTH      held: threshold found (0 when not found)
//  probes    out  $clog2(WIDTH+2)  held: probe count of last search
// BEHAVIOUR
//  Reset: state=IDLE, x_out=0, busy=0, done=0, found=0, result=0, probes=0, lo=0, hi=MAX.
//  States IDLE -> PROBE -> DONE -> IDLE. IDLE & start: lo=0, hi=MAX, x_out=MAX>>1,
//   probes=0, found=0, result=0, go PROBE.
//  PROBE: comparator path is combinational; eq_in/grt_in sampled on the same edge that
//   ends the cycle x_out is presented. One probe per cycle; probes increments per sample.
//   eq_in=1: result=x_out, found=1 -> DONE (eq wins over grt if both high).
//   grt_in=1: if x_out==0 -> DONE, found=0; else hi=x_out-1.
//   else:     if x_out==MAX -> DONE, found=0; else lo=x_out+1.
//   If new lo>hi -> DONE, found=0. Else x_out=(lo+hi)>>1 computed in WIDTH+1 bits.
//  Max probes WIDTH+1 (9 for WIDTH=8); probes never wraps.
//  DONE: done=1 for exactly one cycle, -> IDLE unconditionally; start ignored in DONE.
//  start while busy or in DONE is ignored (no restart, no queueing).
//  x_out holds its last probe value after search ends until next start.
//  rst mid-search: immediate return to reset values, no done pulse.
// CONFIGURATION
//  THRESH_SEARCH_SETTLE_EN defined: SETTLE state inserted after every x_out update
//   (PROBE entered one cycle later); flags sampled only in PROBE -> 2 cycles/probe,
//   for registered comparators. busy high in SETTLE. Undefined: 1 cycle/probe.
// STRUCTURE
//  thresh_search_pkg: state enum typedef (IDLE, SETTLE, PROBE, DONE), state width
//   constant; SETTLE encoding present regardless of macro.
//  No RTL sub-module; comparator is external. Bench pairs DUT with a T-parameterisable
//   comparator model (eq/grt) as responder.
// TESTING
//  T=159: start -> x_out 127,191,159; done at cycle 4 after start; result=159, found=1, probes=3.
//  T=0: x_out 127,63,31,15,7,3,1,0 -> result=0, found=1, probes=8.
//  T=255: x_out 127,191,223,239,247,251,253,254,255 -> result=255, found=1, probes=9.
//  eq_in=0,grt_in=0 tied: probes 9 ending x_out=255 -> done, found=0, result=0.
//  start pulsed during PROBE: ignored, sequence unchanged; rst at 2nd probe -> all outputs 0,
//   no done; next start completes normally.
//  THRESH_SEARCH_SETTLE_EN, T=159: same x_out sequence, each held 2 cycles; done 7 cycles after start.

Source files
------------

// File: rtl/thresh_search_pkg.sv
// Shared types for the threshold search controller.
// The SETTLE encoding always exists so the state width is independent of build options.
package thresh_search_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PROBE  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/thresh_search.sv
// Binary-search controller that locates the hard-wired threshold of an external comparator.
// Define THRESH_SEARCH_SETTLE_EN to add a SETTLE cycle after every probe update (registered comparators).
module thresh_search #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          eq_in,
    input  logic                          grt_in,
    output logic [WIDTH-1:0]              x_out,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [WIDTH-1:0]              result,
    output logic [$clog2(WIDTH+2)-1:0]    probes
);
    import thresh_search_pkg::*;

    localparam int unsigned PW = $clog2(WIDTH + 2);
    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH-1:0] ONE   = 1;
    localparam logic [PW-1:0]    P_ONE = 1;

`ifdef THRESH_SEARCH_SETTLE_EN
    localparam state_t AFTER_UPDATE = SETTLE;
`else
    localparam state_t AFTER_UPDATE = PROBE;
`endif

    state_t           state;
    logic [WIDTH-1:0] lo, hi;
    logic [WIDTH-1:0] lo_n, hi_n, mid_n;
    logic [WIDTH:0]   sum_n;
    logic             end_n;

    // Next search window from the current comparator flags; eq has priority over grt.
    always_comb begin
        lo_n  = lo;
        hi_n  = hi;
        end_n = 1'b0;
        if (eq_in) begin
            end_n = 1'b1;
        end else if (grt_in) begin
            if (x_out == '0) end_n = 1'b1;
            else             hi_n  = x_out - ONE;
        end else begin
            if (x_out == MAX) end_n = 1'b1;
            else              lo_n  = x_out + ONE;
        end
        if (!end_n && (lo_n > hi_n)) end_n = 1'b1;
        sum_n = {1'b0, lo_n} + {1'b0, hi_n};
        mid_n = sum_n[WIDTH:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x_out  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            result <= '0;
            probes <= '0;
            lo     <= '0;
            hi     <= MAX;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lo     <= '0;
                        hi     <= MAX;
                        x_out  <= {1'b0, MAX[WIDTH-1:1]};
                        probes <= '0;
                        found  <= 1'b0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= AFTER_UPDATE;
                    end
                end
                SETTLE: state <= PROBE;
                PROBE: begin
                    if (probes != '1) probes <= probes + P_ONE;
                    if (eq_in) begin
                        result <= x_out;
                        found  <= 1'b1;
                    end
                    // x_out is left at the final probe value on every exit path.
                    if (end_n) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        lo    <= lo_n;
                        hi    <= hi_n;
                        x_out <= mid_n;
                        state <= AFTER_UPDATE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thresh_search.sv
// Self-checking bench for thresh_search paired with a constant-threshold comparator model.
module tb_thresh_search;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned MAXV  = (1 << WIDTH) - 1;
`ifdef THRESH_SEARCH_SETTLE_EN
    localparam int unsigned CPP = 2;
`else
    localparam int unsigned CPP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             eq_in, grt_in;
    logic [WIDTH-1:0] x_out, result;
    logic             busy, done, found;
    logic [3:0]       probes;

    logic [WIDTH-1:0] thr;
    logic             tie;

    // Comparator responder; tie forces both flags low.
    assign eq_in  = !tie && (x_out == thr);
    assign grt_in = !tie && (x_out >  thr);

    always #5 clk = ~clk;

    thresh_search #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .eq_in  (eq_in),
        .grt_in (grt_in),
        .x_out  (x_out),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .probes (probes)
    );

    typedef struct {
        int unsigned t;
        bit          tie;
        int unsigned exp_result;
        bit          exp_found;
        int unsigned exp_probes;
    } vec_t;

    typedef struct {
        int unsigned result;
        bit          found;
        int unsigned probes;
        int unsigned latency;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned x_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference binary search producing the expected probe sequence.
    function automatic void model(input int unsigned t, input bit tie_m);
        int unsigned lo = 0;
        int unsigned hi = MAXV;
        int unsigned x;
        x_q.delete();
        for (int unsigned i = 0; i < 20; i++) begin
            x = (lo + hi) / 2;
            x_q.push_back(x);
            if (!tie_m && x == t) return;
            if (!tie_m && x > t) begin
                if (x == 0) return;
                hi = x - 1;
            end else begin
                if (x == MAXV) return;
                lo = x + 1;
            end
            if (lo > hi) return;
        end
    endfunction

    task automatic run(input vec_t v, input int unsigned glitch_k, input bit start_in_done);
        int unsigned k;
        int unsigned exp_x;
        exp_t        e;
        thr = v.t[WIDTH-1:0];
        tie = v.tie;
        model(v.t, v.tie);
        exp_q.push_back(exp_t'{v.exp_result, v.exp_found, v.exp_probes, v.exp_probes * CPP});
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (k < 40 && !done) begin
            exp_x = (k / CPP < x_q.size()) ? x_q[k / CPP] : 9999;
            check("busy_during_search", busy, 1);
            check("x_out_probe", x_out, exp_x);
            start = (k == glitch_k);
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        e = exp_q.pop_front();
        if (!done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_latency", k, e.latency);
            check("result", result, e.result);
            check("found", found, e.found);
            check("probes", probes, e.probes);
            check("busy_at_done", busy, 0);
            check("x_out_held", x_out, x_q[x_q.size() - 1]);
        end
        if (start_in_done) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        @(negedge clk);
        check("no_restart_from_done", busy, 0);
        check("result_held", result, e.result);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{159, 0, 159, 1, 3};
        vecs[1] = '{0,   0, 0,   1, 8};
        vecs[2] = '{255, 0, 255, 1, 9};
        vecs[3] = '{0,   1, 0,   0, 9};
        vecs[4] = '{127, 0, 127, 1, 1};
        vecs[5] = '{128, 0, 128, 1, 8};

        rst   = 1'b1;
        start = 1'b0;
        tie   = 1'b0;
        thr   = '0;
        @(negedge clk);
        check("rst_x_out", x_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_result", result, 0);
        check("rst_probes", probes, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int unsigned i = 0; i < 6; i++) run(vecs[i], 999, 1'b0);

        // start pulsed mid-search and again while DONE: both must be ignored.
        run(vecs[0], 1, 1'b1);
        run(vecs[1], 2, 1'b1);

        // Reset asserted while the second probe is on x_out.
        thr = 8'd200;
        tie = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (CPP) @(negedge clk);
        check("pre_rst_x_out", x_out, 191);
        rst = 1'b1;
        #1;
        check("midrst_x_out", x_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_found", found, 0);
        check("midrst_result", result, 0);
        check("midrst_probes", probes, 0);
        @(negedge clk) rst = 1'b0;
        for (int unsigned i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_rst", done, 0);
            check("idle_after_rst", busy, 0);
        end

        run(vecs[0], 999, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
